// File: rtl/xain_pkg.sv
// Shared definitions for the SDRAM ROM download/readback paths.
package xain_pkg;

  // Byte-address width of the SDRAM ch3 port, shared with rom_loader
  localparam int unsigned SDR_BYTE_ADDR_W = 25;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    EMIT_LO,
    EMIT_HI,
    FIN
  } rom_reader_state_t;

endpackage

// File: rtl/sdram_rom_reader.sv
// sdram_rom_reader: walks a byte range of SDRAM over the 16-bit ch3 read channel
// and emits it as a valid/ready byte stream (ROM verify / upload).
// Optional feature: define ROM_READER_CHECKSUM_EN to enable the running byte sum.
module sdram_rom_reader
  import xain_pkg::*;
#(
  parameter int unsigned ADDR_W      = SDR_BYTE_ADDR_W,
  parameter int unsigned LEN_W       = 24,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic              sdr_req,
  input  logic [15:0]       sdr_dout,
  input  logic              sdr_rdy,
  output logic [7:0]        out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       checksum
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  rom_reader_state_t  state;
  logic [ADDR_W-1:0]  ptr;
  logic [LEN_W-1:0]   remaining;
  logic [15:0]        word;
  logic [TMO_W-1:0]   tmo;
  logic               handshake_c;
  logic               last_byte_c;

  assign handshake_c = out_valid & out_ready;
  assign last_byte_c = (remaining == LEN_W'(1));

  // Transfer sequencer: request a word, wait for it, serialize its bytes
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      sdr_addr  <= '0;
      sdr_req   <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
      remaining <= '0;
      word      <= '0;
      tmo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            busy      <= 1'b1;
            error     <= 1'b0;
            remaining <= length;
            out_addr  <= base_addr;
            ptr       <= {base_addr[ADDR_W-1:1], 1'b0};
            if (length == '0) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          sdr_addr <= ptr;
          sdr_req  <= 1'b1;
          tmo      <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          tmo <= tmo + TMO_W'(1);
          if (sdr_rdy) begin
            word    <= sdr_dout;
            sdr_req <= 1'b0;
            state   <= EMIT_LO;
          end else if (tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
            sdr_req <= 1'b0;
            error   <= 1'b1;
            done    <= 1'b1;
            state   <= FIN;
          end
        end
        EMIT_LO: begin
          if (!out_valid) begin
            // First presentation of this word; an odd byte address skips the low half
            out_valid <= 1'b1;
            if (out_addr[0]) begin
              out_data <= word[15:8];
              state    <= EMIT_HI;
            end else begin
              out_data <= word[7:0];
            end
          end else if (out_ready) begin
            out_addr  <= out_addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            if (last_byte_c) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= FIN;
            end else begin
              out_data <= word[15:8];
              state    <= EMIT_HI;
            end
          end
        end
        EMIT_HI: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_addr  <= out_addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            if (last_byte_c) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              // Issue the next word request directly to keep the stream dense
              ptr      <= ptr + ADDR_W'(2);
              sdr_addr <= ptr + ADDR_W'(2);
              sdr_req  <= 1'b1;
              tmo      <= '0;
              state    <= WAIT;
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROM_READER_CHECKSUM_EN
  // Running byte sum of every byte accepted by the consumer
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if (state == IDLE && start) begin
      checksum <= '0;
    end else if (handshake_c) begin
      checksum <= checksum + 16'(out_data);
    end
  end
`else
  assign checksum = 16'h0000;
`endif

endmodule
